// File: rtl/req_pulse_gen.sv
// req_pulse_gen: upstream request generator for a req/ack handshake channel.
// On an accepted start it issues num_req single-cycle req pulses, waits for
// an ack after each one, inserts gap idle cycles between an ack and the next
// req, and aborts the command if no ack arrives within TIMEOUT cycles.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   command pulse, sampled only while idle
//   num_req      in   requests per command, latched on accepted start
//   gap          in   idle cycles between ack and next req, latched on start
//   ack          in   acknowledge from responder
//   req          out  one-cycle request pulse
//   busy         out  command in progress
//   done         out  one-cycle end-of-command pulse (normal or aborted)
//   timeout_err  out  sticky: a wait for ack expired
//   spurious_ack out  sticky: ack seen outside the wait window while busy
//   req_cnt      out  requests issued in the current command
//   ack_cnt      out  acks accepted in the current command
module req_pulse_gen #(
  parameter int CNT_W   = 8,
  parameter int GAP_W   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_req,
  input  logic [GAP_W-1:0] gap,
  input  logic             ack,
  output logic             req,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic             spurious_ack,
  output logic [CNT_W-1:0] req_cnt,
  output logic [CNT_W-1:0] ack_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  // ST_ARM is the setup cycle after an accepted start, so the first req
  // appears one cycle after the start edge.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_REQ,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [CNT_W-1:0] r_num_req;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gap_tmr;
  logic [TMR_W-1:0] r_wait_tmr;

  logic             r_req;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout_err;
  logic             r_spurious_ack;
  logic [CNT_W-1:0] r_req_cnt;
  logic [CNT_W-1:0] r_ack_cnt;

  logic             w_start_ok;
  logic             w_load;
  logic             w_ack_ok;
  logic             w_wait_exp;
  logic             w_spur;

  logic             w_req_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_to_nxt;
  logic             w_sp_nxt;
  logic [CNT_W-1:0] w_req_cnt_nxt;
  logic [CNT_W-1:0] w_ack_cnt_nxt;

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_load     = w_start_ok && (num_req != '0);
  assign w_ack_ok   = (r_state == ST_WAIT) && ack;
  assign w_wait_exp = (r_state == ST_WAIT) && !ack &&
                      (r_wait_tmr == TMR_W'(TIMEOUT));
  assign w_spur     = ack && ((r_state == ST_ARM) || (r_state == ST_REQ) ||
                              (r_state == ST_GAP) || (r_state == ST_DONE));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_load) w_next = ST_ARM;
      ST_ARM:  w_next = ST_REQ;
      ST_REQ:  w_next = ST_WAIT;
      ST_WAIT: begin
        if (ack) begin
          if (r_req_cnt == r_num_req) w_next = ST_DONE;
          else if (r_gap == '0)       w_next = ST_REQ;
          else                        w_next = ST_GAP;
        end else if (w_wait_exp) begin
          w_next = ST_DONE;
        end
      end
      ST_GAP:  if (r_gap_tmr == r_gap) w_next = ST_REQ;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Output logic: every output is registered from the upcoming state so
  // req/busy/done line up with the state they describe.
  always_comb begin
    w_req_nxt     = (w_next == ST_REQ);
    w_busy_nxt    = (w_next != ST_IDLE);
    w_done_nxt    = (w_next == ST_DONE) || (w_start_ok && (num_req == '0));
    w_req_cnt_nxt = r_req_cnt;
    w_ack_cnt_nxt = r_ack_cnt;
    if (w_load) begin
      w_req_cnt_nxt = '0;
      w_ack_cnt_nxt = '0;
    end else begin
      if (w_next == ST_REQ) w_req_cnt_nxt = r_req_cnt + 1'b1;
      if (w_ack_ok)         w_ack_cnt_nxt = r_ack_cnt + 1'b1;
    end
    w_to_nxt = w_start_ok ? 1'b0 : (r_timeout_err | w_wait_exp);
    w_sp_nxt = w_start_ok ? 1'b0 : (r_spurious_ack | w_spur);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req          <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_spurious_ack <= 1'b0;
      r_req_cnt      <= '0;
      r_ack_cnt      <= '0;
    end else begin
      r_req          <= w_req_nxt;
      r_busy         <= w_busy_nxt;
      r_done         <= w_done_nxt;
      r_timeout_err  <= w_to_nxt;
      r_spurious_ack <= w_sp_nxt;
      r_req_cnt      <= w_req_cnt_nxt;
      r_ack_cnt      <= w_ack_cnt_nxt;
    end
  end

  // Command parameters and the wait/gap timers. Each timer starts at 1 on
  // entry to its state and counts up while the state is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num_req  <= '0;
      r_gap      <= '0;
      r_gap_tmr  <= '0;
      r_wait_tmr <= '0;
    end else begin
      if (w_load) begin
        r_num_req <= num_req;
        r_gap     <= gap;
      end
      if (w_next == ST_WAIT) begin
        r_wait_tmr <= (r_state == ST_WAIT) ? r_wait_tmr + 1'b1 : TMR_W'(1);
      end
      if (w_next == ST_GAP) begin
        r_gap_tmr <= (r_state == ST_GAP) ? r_gap_tmr + 1'b1 : GAP_W'(1);
      end
    end
  end

  assign req          = r_req;
  assign busy         = r_busy;
  assign done         = r_done;
  assign timeout_err  = r_timeout_err;
  assign spurious_ack = r_spurious_ack;
  assign req_cnt      = r_req_cnt;
  assign ack_cnt      = r_ack_cnt;

endmodule

// File: tb/tb_req_pulse_gen.sv
// Self-checking bench for req_pulse_gen: a timestamp-based reference model
// (request times, ack windows, end-of-command time) is compared against the
// DUT every cycle, plus literal expectations for the directed scenarios.
module tb_req_pulse_gen;
  localparam int CNT_W   = 8;
  localparam int GAP_W   = 4;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_req = '0;
  logic [GAP_W-1:0] gap = '0;
  logic             ack = 1'b0;
  logic             req, busy, done, timeout_err, spurious_ack;
  logic [CNT_W-1:0] req_cnt, ack_cnt;

  int tests = 0;
  int fails = 0;

  req_pulse_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .num_req(num_req), .gap(gap),
    .ack(ack), .req(req), .busy(busy), .done(done),
    .timeout_err(timeout_err), .spurious_ack(spurious_ack),
    .req_cnt(req_cnt), .ack_cnt(ack_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model. cyc is the index of the last rising edge; expectations
  // describe the cycle that follows that edge.
  int cyc  = 0;
  bit m_run = 0;   // command in progress during the cycle after edge cyc
  int m_rt = 0;    // edge at which the current/next req goes high
  int m_d  = -1;   // edge at which done goes high (-1: not yet known)
  int m_iss = 0, m_ack = 0, m_n = 0, m_g = 0;
  bit m_to = 0, m_sp = 0;
  bit e_req = 0, e_busy = 0, e_done = 0;

  always @(posedge clk or posedge rst) begin
    bit in_win;
    if (rst) begin
      m_run = 0; m_rt = 0; m_d = -1; m_iss = 0; m_ack = 0; m_n = 0; m_g = 0;
      m_to = 0; m_sp = 0; e_req = 0; e_busy = 0; e_done = 0;
    end else begin
      cyc = cyc + 1;
      e_done = 0;
      if (!m_run) begin
        if (start) begin
          m_to = 0; m_sp = 0;
          if (num_req != 0) begin
            m_run = 1; m_n = int'(num_req); m_g = int'(gap);
            m_iss = 0; m_ack = 0; m_rt = cyc + 1; m_d = -1;
          end else begin
            e_done = 1;
          end
        end
      end else begin
        // ack counts only in the TIMEOUT edges following the edge where req drops
        in_win = (m_iss > m_ack) && (m_d < 0) &&
                 (cyc >= m_rt + 2) && (cyc <= m_rt + 1 + TIMEOUT);
        if (ack && !in_win) m_sp = 1;
        if (m_d >= 0 && cyc == m_d + 1) begin
          m_run = 0;
        end else begin
          if (in_win && ack) begin
            m_ack++;
            if (m_ack == m_n) m_d = cyc;
            else              m_rt = cyc + m_g;
          end else if ((m_iss > m_ack) && (m_d < 0) && (cyc == m_rt + 1 + TIMEOUT)) begin
            m_to = 1;
            m_d  = cyc;
          end
          if (m_d < 0 && cyc == m_rt) m_iss++;
        end
      end
      e_req  = m_run && (m_d < 0) && (cyc == m_rt);
      e_busy = m_run;
      if (m_run && m_d == cyc) e_done = 1;
    end
  end

  always @(negedge clk) begin
    chk("req",          req,          e_req);
    chk("busy",         busy,         e_busy);
    chk("done",         done,         e_done);
    chk("timeout_err",  timeout_err,  m_to);
    chk("spurious_ack", spurious_ack, m_sp);
    chk("req_cnt",      req_cnt,      m_iss);
    chk("ack_cnt",      ack_cnt,      m_ack);
  end

  // Responder: 0 compliant, 1 random delay (may time out), 2 silent,
  // 3 ack held high, 4 random noise.
  int resp_mode = 0;
  int ack_at = -1;

  task automatic step();
    @(negedge clk);
    start = 1'b0;
    case (resp_mode)
      0, 1: begin
        ack = (cyc == ack_at);
        if (req) ack_at = cyc + ((resp_mode == 0) ? 1 : int'($urandom_range(1, TIMEOUT + 2)));
      end
      2:       ack = 1'b0;
      3:       ack = 1'b1;
      default: ack = ($urandom_range(0, 3) == 0);
    endcase
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy=1 after %0d cycles, expected 0", budget);
    end
  endtask

  // Issues one command and records, per offset from the start edge, where
  // req, done, busy were high and when timeout_err first rose.
  task automatic run_cmd(input int n, input int g, input int mode, input int busy_at,
                         output logic [31:0] rm, output logic [31:0] dm,
                         output logic [31:0] bm, output int to_off);
    int s, off;
    resp_mode = mode;
    step();
    start = 1'b1; num_req = CNT_W'(n); gap = GAP_W'(g);
    s = cyc + 1;
    rm = '0; dm = '0; bm = '0; to_off = -1;
    for (int i = 0; i < 16; i++) begin
      step();
      off = cyc - s;
      if (off >= 0 && off < 32) begin
        if (req)  rm |= (32'd1 << off);
        if (done) dm |= (32'd1 << off);
        if (busy) bm |= (32'd1 << off);
        if (timeout_err && to_off < 0) to_off = off;
      end
      if (off == busy_at) begin
        start = 1'b1; num_req = CNT_W'(5); gap = '0;
      end
    end
  endtask

  logic [31:0] rm, dm, bm;
  int          to_off;

  initial begin
    #1 rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", {req_cnt, ack_cnt}, 0);

    // Normal: 3 requests, gap 0
    run_cmd(3, 0, 0, -1, rm, dm, bm, to_off);
    chk("norm_req_cycles", rm, 32'h2A);
    chk("norm_done_cycle", dm, 32'h80);
    chk("norm_req_cnt", req_cnt, 3);
    chk("norm_ack_cnt", ack_cnt, 3);
    chk("norm_flags", {timeout_err, spurious_ack}, 0);

    // Gap of 3
    run_cmd(2, 3, 0, -1, rm, dm, bm, to_off);
    chk("gap_req_cycles", rm, 32'h42);
    chk("gap_done_cycle", dm, 32'h100);
    chk("gap_ack_cnt", ack_cnt, 2);

    // Timeout: responder silent
    run_cmd(2, 0, 2, -1, rm, dm, bm, to_off);
    chk("to_req_cycles", rm, 32'h2);
    chk("to_done_cycle", dm, 32'h400);
    chk("to_flag_cycle", to_off, 10);
    chk("to_req_cnt", req_cnt, 1);
    chk("to_ack_cnt", ack_cnt, 0);
    run_cmd(1, 0, 0, -1, rm, dm, bm, to_off);
    chk("to_cleared", timeout_err, 0);
    chk("to_next_req", rm, 32'h2);

    // Held ack
    run_cmd(2, 2, 3, -1, rm, dm, bm, to_off);
    chk("held_req_cycles", rm, 32'h22);
    chk("held_done_cycle", dm, 32'h80);
    chk("held_ack_cnt", ack_cnt, 2);
    chk("held_spurious", spurious_ack, 1);

    // Zero-request start
    run_cmd(0, 0, 0, -1, rm, dm, bm, to_off);
    chk("zero_done_cycle", dm, 32'h1);
    chk("zero_no_req", rm, 0);
    chk("zero_no_busy", bm, 0);
    chk("zero_sp_cleared", spurious_ack, 0);

    // Start while busy is ignored
    run_cmd(2, 0, 0, 2, rm, dm, bm, to_off);
    chk("busy_start_req", rm, 32'h0A);
    chk("busy_start_done", dm, 32'h20);
    chk("busy_start_cnt", {req_cnt, ack_cnt}, {8'd2, 8'd2});

    // Reset in the middle of a long command
    resp_mode = 0;
    step();
    start = 1'b1; num_req = CNT_W'(200); gap = GAP_W'(1);
    repeat (6) step();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", {req_cnt, ack_cnt}, 0);
    repeat (5) step();
    rst = 1'b0;
    ack_at = -1;
    run_cmd(1, 0, 0, -1, rm, dm, bm, to_off);
    chk("post_rst_req", rm, 32'h2);
    chk("post_rst_done", dm, 32'h8);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      step();
      if ($urandom_range(0, 63) == 0) resp_mode = int'($urandom_range(0, 4));
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        ack_at = -1;
      end else if ($urandom_range(0, 5) == 0) begin
        start   = 1'b1;
        num_req = ($urandom_range(0, 9) == 0) ? '0 : CNT_W'($urandom_range(1, 8));
        gap     = GAP_W'($urandom_range(0, 3));
      end
    end
    resp_mode = 0;
    wait_idle(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
